// File: rtl/dispatch_pkg.sv
// Shared decode constants, functional-unit index, ext codes and dispatch FSM states.
// Optional mul/div routing is controlled by DISPATCH_MULDIV_EN in the decode sub-module.
package dispatch_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Bit position of each unit in q_full / q_en.
    typedef enum logic [1:0] {
        ALU = 2'd0,
        AGU = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } unit_e;

    // ALU operand-selection codes carried on q_ext.
    localparam logic [2:0] EXT_REG   = 3'd0;
    localparam logic [2:0] EXT_JAL   = 3'd1;
    localparam logic [2:0] EXT_JALR  = 3'd2;
    localparam logic [2:0] EXT_BR    = 3'd3;
    localparam logic [2:0] EXT_IMM   = 3'd4;
    localparam logic [2:0] EXT_UPPER = 3'd5;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        unit_e      unit;
        logic [2:0] ext;
        logic       ls;
        logic       wr_rd;
        logic       use_rs1;
        logic       use_rs2;
        logic       is_br;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/dispatch_sched_if.sv
// Instruction-queue, issue-queue, ROB-tag and CDB signals of the dispatch scheduler.
// master = surrounding pipeline, slave = dispatch_sched.
interface dispatch_sched_if #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
);
    logic             ifq_valid;
    logic [XLEN-1:0]  ifq_instr;
    logic             ifq_rd_en;
    logic [3:0]       q_full;
    logic             tag_avail;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             br_resolved;
    logic             flush;
    logic [3:0]       q_en;
    logic [2:0]       q_ext;
    logic             q_ls;
    logic [TAG_W-1:0] q_tag;
    logic             q_rs1_busy;
    logic [TAG_W-1:0] q_rs1_tag;
    logic             q_rs2_busy;
    logic [TAG_W-1:0] q_rs2_tag;
    logic [XLEN-1:0]  q_instr;
    logic             illegal;

    modport master (
        output ifq_valid, ifq_instr, q_full, tag_avail, cdb_valid, cdb_tag, br_resolved, flush,
        input  ifq_rd_en, q_en, q_ext, q_ls, q_tag, q_rs1_busy, q_rs1_tag, q_rs2_busy, q_rs2_tag,
               q_instr, illegal
    );

    modport slave (
        input  ifq_valid, ifq_instr, q_full, tag_avail, cdb_valid, cdb_tag, br_resolved, flush,
        output ifq_rd_en, q_en, q_ext, q_ls, q_tag, q_rs1_busy, q_rs1_tag, q_rs2_busy, q_rs2_tag,
               q_instr, illegal
    );

endinterface

// File: rtl/dispatch_decode.sv
// Purpose: opcode/funct decode to target unit, ext code and register usage (DISPATCH_MULDIV_EN adds mul/div).
// Latency: purely combinational.
// Backpressure: none; the scheduler qualifies the result with queue-full and tag state.
module dispatch_decode
    import dispatch_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

`ifndef DISPATCH_MULDIV_EN
    logic funct3_unused;
    assign funct3_unused = ^funct3;
`endif

    always_comb begin
        dec      = '0;
        dec.unit = ALU;
        case (opcode)
            OPC_OP: begin
                dec.wr_rd   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.ext     = EXT_REG;
                if (funct7 == 7'h00 || funct7 == 7'h20) begin
                    dec.unit = ALU;
                end
`ifdef DISPATCH_MULDIV_EN
                else if (funct7 == 7'h01) begin
                    dec.unit = funct3[2] ? DIV : MUL;
                end
`endif
                else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.wr_rd   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.ext     = EXT_IMM;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.wr_rd = 1'b1;
                dec.ext   = EXT_UPPER;
            end
            OPC_BRANCH: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.is_br   = 1'b1;
                dec.ext     = EXT_BR;
            end
            OPC_JAL: begin
                dec.wr_rd = 1'b1;
                dec.is_br = 1'b1;
                dec.ext   = EXT_JAL;
            end
            OPC_JALR: begin
                dec.wr_rd   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.is_br   = 1'b1;
                dec.ext     = EXT_JALR;
            end
            OPC_LOAD: begin
                dec.unit    = AGU;
                dec.wr_rd   = 1'b1;
                dec.use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.unit    = AGU;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.ls      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dispatch_sched.sv
// Purpose: in-order dispatch to alu/agu(/mul/div with DISPATCH_MULDIV_EN) with ROB tags and register status.
// Latency: ifq_rd_en combinational; q_* and illegal registered one cycle after the pop.
// Backpressure: head held while its queue is full, no tag is free, a branch is pending or flush is high.
module dispatch_sched
    import dispatch_pkg::*;
#(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
) (
    input logic            clk,
    input logic            rst_n,
    dispatch_sched_if.slave io
);

    localparam int NREG = 32;
`ifdef DISPATCH_MULDIV_EN
    localparam logic [3:0] UNIT_MASK = 4'b1111;
`else
    localparam logic [3:0] UNIT_MASK = 4'b0011;
`endif

    state_e           state, state_nxt;
    logic [TAG_W-1:0] tag_cnt;
    logic [NREG-1:0]  busy;
    logic [TAG_W-1:0] rtag [NREG];

    dec_t             dec;
    logic [4:0]       rd, rs1, rs2;
    logic [3:0]       full_eff;
    logic             run_ok, fire, ill_pop, wr_en;
    logic             rs1_busy, rs2_busy;
    logic [TAG_W-1:0] rs1_tag, rs2_tag;

    assign rd  = io.ifq_instr[11:7];
    assign rs1 = io.ifq_instr[19:15];
    assign rs2 = io.ifq_instr[24:20];

    dispatch_decode u_decode (
        .opcode (io.ifq_instr[6:0]),
        .funct3 (io.ifq_instr[14:12]),
        .funct7 (io.ifq_instr[31:25]),
        .dec    (dec)
    );

    assign full_eff   = io.q_full & UNIT_MASK;
    assign run_ok     = rst_n && (state == RUN) && !io.flush && io.ifq_valid;
    assign fire       = run_ok && !dec.illegal && !full_eff[dec.unit] && io.tag_avail;
    assign ill_pop    = run_ok && dec.illegal;
    assign io.ifq_rd_en = fire || ill_pop;
    assign wr_en      = fire && dec.wr_rd && (rd != 5'd0);

    // A producer completing this cycle is already visible to the dispatching consumer.
    assign rs1_busy = dec.use_rs1 && (rs1 != 5'd0) && busy[rs1] &&
                      !(io.cdb_valid && (io.cdb_tag == rtag[rs1]));
    assign rs2_busy = dec.use_rs2 && (rs2 != 5'd0) && busy[rs2] &&
                      !(io.cdb_valid && (io.cdb_tag == rtag[rs2]));
    assign rs1_tag  = rs1_busy ? rtag[rs1] : '0;
    assign rs2_tag  = rs2_busy ? rtag[rs2] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (io.flush) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (fire && dec.is_br) state_nxt = BR_WAIT;
                BR_WAIT: if (io.br_resolved)    state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tag_cnt <= '0;
        else if (fire) tag_cnt <= tag_cnt + 1'b1;
    end

    // Entry 0 is never written, so x0 stays not-busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (io.flush) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en && (rd == i[4:0])) begin
                    busy[i] <= 1'b1;
                end else if (io.cdb_valid && busy[i] && (rtag[i] == io.cdb_tag)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) rtag[rd] <= tag_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.q_en       <= '0;
            io.q_ext      <= '0;
            io.q_ls       <= 1'b0;
            io.q_tag      <= '0;
            io.q_rs1_busy <= 1'b0;
            io.q_rs1_tag  <= '0;
            io.q_rs2_busy <= 1'b0;
            io.q_rs2_tag  <= '0;
            io.q_instr    <= '0;
            io.illegal    <= 1'b0;
        end else begin
            io.q_en    <= fire ? ((4'b0001 << dec.unit) & UNIT_MASK) : 4'b0000;
            io.illegal <= ill_pop;
            if (fire) begin
                io.q_ext      <= dec.ext;
                io.q_ls       <= dec.ls;
                io.q_tag      <= tag_cnt;
                io.q_rs1_busy <= rs1_busy;
                io.q_rs1_tag  <= rs1_tag;
                io.q_rs2_busy <= rs2_busy;
                io.q_rs2_tag  <= rs2_tag;
                io.q_instr    <= io.ifq_instr;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_sched.sv
// Randomized and directed stimulus for dispatch_sched against a register-scoreboard reference model.
// Honours DISPATCH_MULDIV_EN the same way as the design build.
module tb_dispatch_sched;

    localparam int TAG_W = 6;
    localparam int XLEN  = 32;
`ifdef DISPATCH_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dispatch_sched_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

    dispatch_sched #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct packed {
        logic       legal;
        logic [1:0] unit;
        logic [2:0] ext;
        logic       ls, wr, u1, u2, br;
    } mdec_t;

    int n_vec = 0;
    int n_err = 0;

    logic             m_busy [32];
    logic [TAG_W-1:0] m_tag  [32];
    logic [TAG_W-1:0] m_cnt;
    logic             m_wait;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {12'h001, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'h00, rs2, rs1, 3'b010, 5'h04, 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'h00, rs2, rs1, 3'b000, 5'h08, 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd);
        return {20'h12345, rd, opc};
    endfunction

    // Reference decode written straight from the instruction-class routing table.
    function automatic mdec_t mdecode(input logic [31:0] ins);
        mdec_t      d;
        logic [6:0] f7;
        logic [2:0] f3;
        d  = '0;
        f7 = ins[31:25];
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33: begin
                d.u1 = 1'b1; d.u2 = 1'b1; d.wr = 1'b1;
                if (f7 == 7'h00 || f7 == 7'h20) d.legal = 1'b1;
                else if (f7 == 7'h01 && MULDIV) begin
                    d.legal = 1'b1;
                    d.unit  = (f3 < 3'd4) ? 2'd2 : 2'd3;
                end
            end
            7'h13: begin d.legal = 1'b1; d.ext = 3'd4; d.wr = 1'b1; d.u1 = 1'b1; end
            7'h37, 7'h17: begin d.legal = 1'b1; d.ext = 3'd5; d.wr = 1'b1; end
            7'h63: begin d.legal = 1'b1; d.ext = 3'd3; d.u1 = 1'b1; d.u2 = 1'b1; d.br = 1'b1; end
            7'h6f: begin d.legal = 1'b1; d.ext = 3'd1; d.wr = 1'b1; d.br = 1'b1; end
            7'h67: begin d.legal = 1'b1; d.ext = 3'd2; d.wr = 1'b1; d.u1 = 1'b1; d.br = 1'b1; end
            7'h03: begin d.legal = 1'b1; d.unit = 2'd1; d.wr = 1'b1; d.u1 = 1'b1; end
            7'h23: begin d.legal = 1'b1; d.unit = 2'd1; d.ls = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_cnt  = '0;
        m_wait = 1'b0;
    endtask

    task automatic set_idle();
        bus.ifq_valid   = 1'b0;
        bus.ifq_instr   = '0;
        bus.q_full      = 4'b0000;
        bus.tag_avail   = 1'b1;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.br_resolved = 1'b0;
        bus.flush       = 1'b0;
    endtask

    // Called 1 time unit after a rising edge with this cycle's inputs already applied.
    task automatic tick();
        mdec_t            d;
        logic             run, fire, ill, b1, b2;
        logic [TAG_W-1:0] t1, t2, e_tag;
        logic [4:0]       rd, r1, r2;
        logic [XLEN-1:0]  ins;
        ins = bus.ifq_instr;
        d   = mdecode(ins);
        rd  = ins[11:7];
        r1  = ins[19:15];
        r2  = ins[24:20];
        run  = bus.ifq_valid && !m_wait && !bus.flush;
        fire = run && d.legal && !bus.q_full[d.unit] && bus.tag_avail;
        ill  = run && !d.legal;
        b1 = d.u1 && r1 != 5'd0 && m_busy[r1] && !(bus.cdb_valid && m_tag[r1] == bus.cdb_tag);
        b2 = d.u2 && r2 != 5'd0 && m_busy[r2] && !(bus.cdb_valid && m_tag[r2] == bus.cdb_tag);
        t1 = b1 ? m_tag[r1] : '0;
        t2 = b2 ? m_tag[r2] : '0;
        e_tag = m_cnt;
        #3;
        check("ifq_rd_en", {63'd0, bus.ifq_rd_en}, {63'd0, fire || ill});
        if (bus.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_wait = 1'b0;
        end else begin
            if (bus.cdb_valid)
                for (int i = 0; i < 32; i++)
                    if (m_busy[i] && m_tag[i] == bus.cdb_tag) m_busy[i] = 1'b0;
            if (fire && d.wr && rd != 5'd0) begin
                m_busy[rd] = 1'b1;
                m_tag[rd]  = m_cnt;
            end
            if (fire) m_cnt = m_cnt + 1'b1;
            if (fire && d.br) m_wait = 1'b1;
            else if (m_wait && bus.br_resolved) m_wait = 1'b0;
        end
        @(posedge clk);
        #1;
        check("q_en", {60'd0, bus.q_en}, {60'd0, fire ? (4'b0001 << d.unit) : 4'b0000});
        check("illegal", {63'd0, bus.illegal}, {63'd0, ill});
        if (fire) begin
            check("q_tag", {58'd0, bus.q_tag}, {58'd0, e_tag});
            check("q_ext", {61'd0, bus.q_ext}, {61'd0, d.ext});
            check("q_ls", {63'd0, bus.q_ls}, {63'd0, d.ls});
            check("q_rs1_busy", {63'd0, bus.q_rs1_busy}, {63'd0, b1});
            check("q_rs1_tag", {58'd0, bus.q_rs1_tag}, {58'd0, t1});
            check("q_rs2_busy", {63'd0, bus.q_rs2_busy}, {63'd0, b2});
            check("q_rs2_tag", {58'd0, bus.q_rs2_tag}, {58'd0, t2});
            check("q_instr", {32'd0, bus.q_instr}, {32'd0, ins});
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.ifq_valid = 1'b1;
        bus.ifq_instr = ins;
        tick();
    endtask

    // Asynchronous reset mid-cycle; the head stays valid to show no pop happens under reset.
    task automatic do_reset();
        rst_n         = 1'b0;
        set_idle();
        bus.ifq_valid = 1'b1;
        bus.ifq_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        #3;
        check("rst_rd_en", {63'd0, bus.ifq_rd_en}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_q_en", {60'd0, bus.q_en}, 64'd0);
        check("rst_q_tag", {58'd0, bus.q_tag}, 64'd0);
        check("rst_illegal", {63'd0, bus.illegal}, 64'd0);
        check("rst_q_instr", {32'd0, bus.q_instr}, 64'd0);
        check("rst_rs_busy", {62'd0, bus.q_rs1_busy, bus.q_rs2_busy}, 64'd0);
        model_reset();
        rst_n = 1'b1;
        set_idle();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        logic [2:0] f3;
        logic [31:0] r;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0, 1:    r = enc_r($urandom_range(0, 1) ? 7'h20 : 7'h00, b, a, f3, c);
            2:       r = enc_r(7'h01, b, a, f3, c);
            3:       r = enc_i(7'h13, c, a, f3);
            4:       r = enc_u(7'h37, c);
            5:       r = enc_u(7'h17, c);
            6:       r = enc_b(b, a);
            7:       r = enc_u(7'h6f, c);
            8:       r = enc_i(7'h67, c, a, 3'd0);
            9:       r = enc_i(7'h03, c, a, 3'd2);
            10:      r = enc_s(b, a);
            default: r = $urandom_range(0, 1) ? enc_u(7'h7f, c) : enc_r(7'h05, b, a, f3, c);
        endcase
        return r;
    endfunction

    initial begin
        set_idle();
        model_reset();
        bus.ifq_valid = 1'b1;
        bus.ifq_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5);
        #3;
        check("reset_rd_en", {63'd0, bus.ifq_rd_en}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_q_en", {60'd0, bus.q_en}, 64'd0);
        check("reset_q_tag", {58'd0, bus.q_tag}, 64'd0);
        check("reset_illegal", {63'd0, bus.illegal}, 64'd0);
        check("reset_q_misc", {59'd0, bus.q_ext, bus.q_ls, bus.q_rs1_busy}, 64'd0);
        rst_n = 1'b1;
        set_idle();

        // Dependency tracking and CDB bypass.
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5));
        check("add_q_en", {60'd0, bus.q_en}, 64'd1);
        check("add_q_tag", {58'd0, bus.q_tag}, 64'd0);
        issue(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6));
        check("dep_rs1_busy", {63'd0, bus.q_rs1_busy}, 64'd1);
        check("dep_rs1_tag", {58'd0, bus.q_rs1_tag}, 64'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd0;
        issue(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd7));
        check("bypass_rs1_busy", {63'd0, bus.q_rs1_busy}, 64'd0);
        bus.cdb_valid = 1'b0;
        issue(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd8));
        check("cleared_rs1_busy", {63'd0, bus.q_rs1_busy}, 64'd0);
        // x7 holds tag 2; rewrite it while tag 2 completes.
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd2;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7));
        bus.cdb_valid = 1'b0;
        issue(enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd9));
        check("wr_beats_cdb_busy", {63'd0, bus.q_rs1_busy}, 64'd1);
        check("wr_beats_cdb_tag", {58'd0, bus.q_rs1_tag}, 64'd4);

        // Full alu queue holds the head.
        bus.q_full = 4'b0001;
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd9));
        check("full_q_en", {60'd0, bus.q_en}, 64'd0);
        bus.q_full = 4'b0000;
        tick();
        check("unfull_q_tag", {58'd0, bus.q_tag}, 64'd6);

        // Branch wait and release.
        issue(enc_b(5'd2, 5'd1));
        check("beq_q_en", {60'd0, bus.q_en}, 64'd1);
        bus.ifq_instr = enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd10);
        repeat (2) tick();
        check("brwait_q_en", {60'd0, bus.q_en}, 64'd0);
        bus.br_resolved = 1'b1;
        tick();
        bus.br_resolved = 1'b0;
        tick();
        check("post_br_q_en", {60'd0, bus.q_en}, 64'd1);
        check("post_br_q_tag", {58'd0, bus.q_tag}, 64'd8);

        // Flush while waiting on a branch.
        issue(enc_b(5'd2, 5'd1));
        bus.ifq_instr = enc_r(7'h00, 5'd6, 5'd10, 3'd0, 5'd11);
        bus.flush     = 1'b1;
        tick();
        check("flush_q_en", {60'd0, bus.q_en}, 64'd0);
        bus.flush = 1'b0;
        tick();
        check("post_flush_q_en", {60'd0, bus.q_en}, 64'd1);
        check("post_flush_busy", {62'd0, bus.q_rs1_busy, bus.q_rs2_busy}, 64'd0);
        check("post_flush_tag", {58'd0, bus.q_tag}, 64'd10);

        // MUL routing depends on the build option.
        issue(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd12));
        check("mul_illegal", {63'd0, bus.illegal}, {63'd0, !MULDIV});
        check("mul_q_en", {60'd0, bus.q_en}, MULDIV ? 64'd4 : 64'd0);
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd13));
        check("after_mul_tag", {58'd0, bus.q_tag}, MULDIV ? 64'd12 : 64'd11);

        // Reset discards a pending branch wait.
        issue(enc_b(5'd2, 5'd1));
        do_reset();
        issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        check("post_rst_q_en", {60'd0, bus.q_en}, 64'd1);
        check("post_rst_tag", {58'd0, bus.q_tag}, 64'd0);

        // Tag wrap after 2^TAG_W fires.
        do_reset();
        for (int i = 0; i < (1 << TAG_W); i++) issue(enc_i(7'h13, 5'd1, 5'd0, 3'd0));
        issue(enc_i(7'h13, 5'd1, 5'd0, 3'd0));
        check("tag_wrap", {58'd0, bus.q_tag}, 64'd0);

        // Random traffic.
        set_idle();
        for (int n = 0; n < 3000; n++) begin
            bus.ifq_valid   = ($urandom_range(0, 9) < 8);
            bus.ifq_instr   = rand_instr();
            bus.q_full      = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            bus.tag_avail   = ($urandom_range(0, 9) != 0);
            bus.cdb_valid   = ($urandom_range(0, 9) < 4);
            bus.cdb_tag     = $urandom_range(0, 1) ? m_tag[$urandom_range(1, 7)]
                                                   : TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
            bus.br_resolved = ($urandom_range(0, 3) == 0);
            bus.flush       = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_sched.md
DISPATCH_SCHED -- requirements
Module: dispatch_sched

Interface
REQ-001 The block SHALL have parameter TAG_W, default 6, giving the tag width; the tag space is 2^TAG_W.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the instruction and PC width.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port ifq_valid, input, 1: the instruction queue head is valid.
REQ-006 The block SHALL have port ifq_instr, input, XLEN: the head instruction.
REQ-007 The block SHALL have port ifq_rd_en, output, 1: pop the head this cycle.
REQ-008 The block SHALL have port q_full, input, 4: full flags for queues {div,mul,agu,alu}.
REQ-009 The block SHALL have port tag_avail, input, 1: the ROB can accept a new tag.
REQ-010 The block SHALL have port cdb_valid/cdb_tag, input, 1/TAG_W: common-data-bus broadcast.
REQ-011 The block SHALL have port br_resolved, input, 1: the pending branch or jump has resolved.
REQ-012 The block SHALL have port flush, input, 1: mispredict recovery.
REQ-013 The block SHALL have port q_en, output, 4: one-hot enqueue strobe, same bit order as q_full.
REQ-014 The block SHALL have outputs q_ext (3), q_ls (1), q_tag (TAG_W), q_rs1_busy/q_rs1_tag, q_rs2_busy/q_rs2_tag and q_instr (XLEN), all qualified by q_en.
REQ-015 The block SHALL have port illegal, output, 1: one-cycle pulse for an undecodable instruction.

Function
REQ-016 Target-queue and ext decode SHALL be: R-type → alu/mul/div per funct7/funct3; OP-IMM, LUI, AUIPC, branch, JAL, JALR → alu with ext 0/4, 5, 5, 3, 1, 2; load/store → agu with q_ls 0/1.
REQ-017 A dispatch fire SHALL require: ifq_valid, state RUN, target q_full bit 0, tag_avail 1 and flush 0.
REQ-018 ifq_rd_en SHALL be combinational and asserted on a fire or on an illegal pop.
REQ-019 q_* outputs SHALL be registered, one cycle after the fire; q_en SHALL be 0 in all other cycles.
REQ-020 The tag counter SHALL start at 0, increment by 1 on each fire, and wrap from 2^TAG_W-1 to 0; illegal pops SHALL NOT consume a tag.
REQ-021 The register status table SHALL have 32 entries, each {busy, tag}.
REQ-022 On a fire with register write and rd≠0, the table SHALL set entry rd to {1, tag}; stores and branches SHALL NOT write the table.
REQ-023 On cdb_valid, every busy entry whose tag equals cdb_tag SHALL clear.
REQ-024 When a dispatch write and a CDB clear hit the same entry in the same cycle, the dispatch write SHALL win.
REQ-025 Source lookup SHALL bypass the CDB: a source whose tag equals cdb_tag with cdb_valid set SHALL be reported not busy; x0 SHALL always be reported not busy.
REQ-026 The FSM SHALL have states RUN and BR_WAIT: a fire of a branch, JAL or JALR moves RUN→BR_WAIT; br_resolved moves BR_WAIT→RUN; no fires occur in BR_WAIT.
REQ-027 On flush, the block SHALL clear all busy bits, force the state to RUN, suppress q_en that cycle and leave the tag counter unchanged; flush has priority over br_resolved and any fire.
REQ-028 An unknown opcode while in RUN SHALL be popped, with illegal pulsed one cycle later and no q_en.

Reset
REQ-029 While rst_n=0, the block SHALL hold state RUN, tag counter 0, all busy bits 0, and q_en, q_ext, q_ls, q_tag, q_rs*, q_instr and illegal at 0.
REQ-030 Reset asserted mid-operation SHALL discard any pending BR_WAIT with no further pops.

Configuration
REQ-031 With DISPATCH_MULDIV_EN defined, funct7=01h R-type instructions SHALL route to mul (funct3<4) or div.
REQ-032 Without DISPATCH_MULDIV_EN, those instructions SHALL be treated as illegal (REQ-028), and q_en[3:2] and the q_full[3:2] inputs SHALL be tied off and ignored.

Structure
REQ-033 Package dispatch_pkg SHALL hold the opcode constants, the unit-index enum (ALU=0, AGU=1, MUL=2, DIV=3), the ext-code constants and the FSM state enum.
REQ-034 The combinational decode SHALL be sub-module dispatch_decode; the status table, tag counter and FSM SHALL reside in dispatch_sched.

Verification
REQ-035 The bench SHALL cover: ADD x5,x1,x2 with all queues empty → next cycle q_en=0001, q_tag=0, entry 5 busy with tag 0; second ADD x6,x5,x0 → q_rs1_busy=1, q_rs1_tag=0.
REQ-036 The bench SHALL cover: cdb_valid with tag 0 in the same cycle as an instruction reading x5 → q_rs1_busy=0, entry 5 cleared.
REQ-037 The bench SHALL cover: q_full=0001 with ADD at the head → ifq_rd_en=0, no q_en; full deasserted → dispatched one cycle later.
REQ-038 The bench SHALL cover: BEQ dispatched → BR_WAIT with the following ADD held; br_resolved → ADD fires the next cycle; flush during BR_WAIT → RUN and all busy bits 0.
REQ-039 The bench SHALL cover: 2^TAG_W consecutive fires → tag wraps to 0; with DISPATCH_MULDIV_EN undefined, MUL → illegal pulse, no q_en, tag unchanged.
